// File: rtl/wide_bram_reader.sv
// Streams a burst of consecutive words out of a synchronous block RAM.
// A two-entry skid FIFO absorbs the one-cycle RAM latency under backpressure.
`ifndef DATA_ADDR_WIDTH
`define DATA_ADDR_WIDTH 10
`endif

module wide_bram_reader #(
    parameter int ADDR_WIDTH = `DATA_ADDR_WIDTH,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   count,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] mem_dout_addr,
    input  logic [DATA_WIDTH-1:0] mem_dout,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  out_ready
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } state_t;

    localparam logic [ADDR_WIDTH:0] ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    state_t                state;
    state_t                state_nxt;

    logic [ADDR_WIDTH-1:0] base_q;
    logic [ADDR_WIDTH:0]   count_q;
    logic [ADDR_WIDTH:0]   issued;
    logic                  inflight;
    logic                  done_q;
    logic                  done_nxt;

    logic [DATA_WIDTH-1:0] fifo [2];
    logic [1:0]            occ;
    logic                  wr_ptr;
    logic                  rd_ptr;

    logic                  accept;
    logic                  issue;
    logic                  last_issue;
    logic                  push;
    logic                  pop;
    logic                  last_pop;
    logic [2:0]            level;

    // Level counts buffered words plus the read in flight, net of this edge's pop.
    always_comb begin
        pop        = (occ != 2'd0) && out_ready;
        push       = inflight;
        level      = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
        issue      = (state == ISSUE) && (level < 3'd2);
        last_issue = issue && ((issued + ONE) == count_q);
        last_pop   = pop && (occ == 2'd1) && !inflight;
        accept     = (state == IDLE) && start && (count != '0);
    end

    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    if (count != '0) begin
                        state_nxt = ISSUE;
                    end else begin
                        done_nxt = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (last_issue) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (last_pop) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_q   <= 1'b0;
            inflight <= 1'b0;
            base_q   <= '0;
            count_q  <= '0;
            issued   <= '0;
        end else begin
            done_q   <= done_nxt;
            inflight <= issue;
            if (accept) begin
                base_q  <= base_addr;
                count_q <= count;
                issued  <= '0;
            end else if (issue) begin
                issued <= issued + ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ    <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            unique case ({push, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
        end
    end

    // Payload storage needs no reset; occupancy alone decides validity.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo[wr_ptr] <= mem_dout;
        end
    end

    assign mem_dout_addr = base_q + issued[ADDR_WIDTH-1:0];
    assign busy          = (state != IDLE);
    assign done          = done_q;
    assign out_valid     = (occ != 2'd0);
    assign out_data      = fifo[rd_ptr];

endmodule

// File: doc/wide_bram_reader.md
WIDE_BRAM_READER -- requirements
Module: wide_bram_reader

Interface
REQ-001 Parameter ADDR_WIDTH, default `DATA_ADDR_WIDTH`, sets the width of the block-RAM word address.
REQ-002 Parameter DATA_WIDTH, default 64, sets the width of the block-RAM word and of the output stream.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assertion, active-low.
REQ-005 start  in  1  single-cycle request to begin a burst; sampled only in IDLE.
REQ-006 base_addr  in  ADDR_WIDTH  first word address of the burst; sampled with start.
REQ-007 count  in  ADDR_WIDTH+1  number of words in the burst; sampled with start; 0 is legal.
REQ-008 busy  out  1  high while a burst is in progress (not IDLE).
REQ-009 done  out  1  one-cycle pulse when a burst completes.
REQ-010 mem_dout_addr  out  ADDR_WIDTH  read address to the synchronous block RAM.
REQ-011 mem_dout  in  DATA_WIDTH  RAM read data, valid one cycle after its address is clocked in.
REQ-012 out_valid  out  1  out_data holds a word.
REQ-013 out_data  out  DATA_WIDTH  current stream word.
REQ-014 out_ready  in  1  consumer accepts the word; a transfer occurs on an edge where out_valid and out_ready are both high.

Function
REQ-015 States: IDLE, ISSUE (reads remaining), DRAIN (all reads issued, words still unaccepted).
REQ-016 IDLE + start + count!=0 -> ISSUE; base_addr and count are latched, and the issue pointer and remaining-issue counter are loaded.
REQ-017 IDLE + start + count==0 -> remain IDLE; done pulses in the following cycle; no read is issued.
REQ-018 start while busy is ignored; the latched base_addr and count are unchanged.
REQ-019 A read is issued on an edge in ISSUE when (buffered words + in-flight reads - transfers on that edge) < 2.
REQ-020 At most one read is in flight; in-flight data is written into an internal 2-entry FIFO on the edge after its issue.
REQ-021 mem_dout_addr = issue pointer. The pointer increments by 1 per issued read and wraps modulo 2^ADDR_WIDTH.
REQ-022 The last read issued -> ISSUE to DRAIN on that edge.
REQ-023 DRAIN: the transfer of the final word -> IDLE, and done is high for exactly the next cycle.
REQ-024 out_valid = FIFO not empty. out_data = FIFO head. Words leave in address order with no loss or duplication.
REQ-025 Once asserted, out_valid and out_data are held stable until the transfer occurs.
REQ-026 Latency: start sampled at edge E0 -> first read issued at E1 -> out_valid high after E2.
REQ-027 Throughput: with out_ready held high, one word transfers per cycle after the first; an N-word burst ends with done in cycle E0+N+2.
REQ-028 If out_ready is low, issuing stalls once the FIFO plus in-flight read total 2. No overflow occurs.
REQ-029 A FIFO push and pop on the same edge leave the occupancy unchanged.
REQ-030 count = 2^ADDR_WIDTH reads every address exactly once, starting at base_addr and wrapping.

Reset
REQ-031 rst_n low asynchronously forces: state IDLE, busy=0, done=0, out_valid=0, FIFO empty, in-flight flag cleared, mem_dout_addr=0.
REQ-032 Reset mid-burst discards buffered and in-flight data. After release, the first new start behaves exactly as from power-up.
REQ-033 out_data is a don't-care while out_valid=0. The bench does not check it.

Verification
REQ-034 RAM preloaded with word[i]=i, base=5, count=4, out_ready=1 -> out_valid high from E2; out_data 5,6,7,8 on consecutive cycles; done pulses once, in cycle E0+6.
REQ-035 count=0 -> done high for exactly the cycle after start; busy stays 0; no out_valid.
REQ-036 base=2^ADDR_WIDTH-2, count=4 -> mem_dout_addr sequence MAX-1, MAX, 0, 1; stream data matches.
REQ-037 count=8, out_ready toggling 1,0,0,1,... -> all 8 words in order, none duplicated; in-flight + FIFO never exceed 2; out_data stable while stalled.
REQ-038 rst_n pulsed low after 3 words of a 10-word burst -> outputs at reset values immediately; a new burst base=0, count=2 yields exactly word0, word1 and one done pulse.
REQ-039 start reasserted with different base_addr while busy -> the original burst completes unchanged, with a single done pulse.
